// File: rtl/bram_arbiter.sv
// Two-port arbiter sharing one simple-dual-port block RAM (port A write, port B read).
// Latency: grant and RAM strobes are combinational; read data valid one cycle after acceptance.
// Backpressure: a requester waits with req high until gnt; the owner is pre-empted after MAX_HOLD grants if the other port waits.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_HOLD   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  m0_req,
  input  logic                  m0_wr,
  input  logic [3:0]            m0_be,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_wr,
  input  logic [3:0]            m1_be,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state;
  logic            last_served;   // 1 = port 1 was served last, so port 0 wins the next tie
  logic [HW-1:0]   hold;
  logic            gnt0_c;
  logic            gnt1_c;

  // Grant decision from current state and live requests
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          if (last_served) gnt0_c = 1'b1;
          else             gnt1_c = 1'b1;
        end else if (m0_req) begin
          gnt0_c = 1'b1;
        end else if (m1_req) begin
          gnt1_c = 1'b1;
        end
      end
      OWN0: begin
        if (m0_req && !(m1_req && hold == HOLD_MAX)) gnt0_c = 1'b1;
        else if (m1_req)                             gnt1_c = 1'b1;
      end
      OWN1: begin
        if (m1_req && !(m0_req && hold == HOLD_MAX)) gnt1_c = 1'b1;
        else if (m0_req)                             gnt0_c = 1'b1;
      end
      default: begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
      end
    endcase
  end

  // Grants are forced low while reset is held so nothing reaches the RAM
  assign m0_gnt = gnt0_c & HRESETn;
  assign m1_gnt = gnt1_c & HRESETn;

  // Read data is shared; rvalid tells each port whether it is theirs
  assign m0_rdata = ram_doutb;
  assign m1_rdata = ram_doutb;

  // Steer the accepted transfer onto the RAM ports; idle ports are driven to zero
  always_comb begin
    ram_addra = '0;
    ram_dina  = '0;
    ram_wea   = '0;
    ram_addrb = '0;
    if (m0_gnt) begin
      if (m0_wr) begin
        ram_addra = m0_addr;
        ram_dina  = m0_wdata;
        ram_wea   = m0_be;
      end else begin
        ram_addrb = m0_addr;
      end
    end else if (m1_gnt) begin
      if (m1_wr) begin
        ram_addra = m1_addr;
        ram_dina  = m1_wdata;
        ram_wea   = m1_be;
      end else begin
        ram_addrb = m1_addr;
      end
    end
  end

  // Ownership, fairness flag and hold counter
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= IDLE;
      last_served <= 1'b1;
      hold        <= '0;
    end else if (m0_gnt) begin
      state       <= OWN0;
      last_served <= 1'b0;
      if (state == OWN0) hold <= (hold == HOLD_MAX) ? hold : hold + HW'(1);
      else               hold <= HW'(1);
    end else if (m1_gnt) begin
      state       <= OWN1;
      last_served <= 1'b1;
      if (state == OWN1) hold <= (hold == HOLD_MAX) ? hold : hold + HW'(1);
      else               hold <= HW'(1);
    end else begin
      state <= IDLE;
      hold  <= '0;
    end
  end

  // Read-valid follows an accepted read by one cycle, aligned with the RAM output register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_wr;
      m1_rvalid <= m1_gnt & ~m1_wr;
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural RAM, arbitration reference model and read-data scoreboard.
// Latency: checks grants/RAM strobes mid-cycle; read data checked one cycle after acceptance.
// Backpressure: random requesters hold nothing between cycles; the model predicts who is accepted.
module tb_bram_arbiter;

  localparam int AW = 12;
  localparam int MH = 8;

  typedef struct packed {
    logic          req;
    logic          wr;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } mreq_t;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [3:0]    m0_be = 0, m1_be = 0;
  logic [AW-1:0] m0_addr = 0, m1_addr = 0;
  logic [31:0]   m0_wdata = 0, m1_wdata = 0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0]   m0_rdata, m1_rdata;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [31:0]   ram_dina;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_doutb = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int          own = -1;
  int          run = 0;
  int          last = 1;
  logic [31:0] shadow [int];
  exp_t        sbq [$];
  logic [31:0] last_rd [2];

  bram_arbiter #(.ADDR_WIDTH(AW), .MAX_HOLD(MH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural block RAM: byte-write port A, registered read port B
  logic [31:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
  always @(posedge HCLK) begin
    for (int b = 0; b < 4; b++)
      if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    ram_doutb <= mem[ram_addrb];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  // Who should be accepted: fair tie-break from idle, owner keeps the RAM
  // until it stops asking or has used up its hold allowance while the other waits.
  function automatic int predict(input logic r0, input logic r1);
    logic r [2];
    r[0] = r0; r[1] = r1;
    if (own < 0) begin
      if (r0 && r1) return 1 - last;
      if (r0) return 0;
      if (r1) return 1;
      return -1;
    end
    if (r[own] && !(r[1-own] && run >= MH)) return own;
    if (r[1-own]) return 1 - own;
    return -1;
  endfunction

  task automatic model_reset();
    own = -1; run = 0; last = 1;
    sbq.delete();
  endtask

  // One bus cycle: drive after the edge, check combinational outputs mid-cycle, update the model
  task automatic cyc(input mreq_t a, input mreq_t b, output logic [1:0] obs);
    int    g;
    mreq_t w;
    logic [31:0] nv;
    @(posedge HCLK); #1;
    m0_req = a.req; m0_wr = a.wr; m0_be = a.be; m0_addr = a.addr; m0_wdata = a.wdata;
    m1_req = b.req; m1_wr = b.wr; m1_be = b.be; m1_addr = b.addr; m1_wdata = b.wdata;
    @(negedge HCLK);
    obs = {m1_gnt, m0_gnt};
    g = predict(a.req, b.req);
    check("m0_gnt", {31'h0, m0_gnt}, {31'h0, g == 0});
    check("m1_gnt", {31'h0, m1_gnt}, {31'h0, g == 1});
    w = (g == 1) ? b : a;
    check("ram_wea",   {28'h0, ram_wea},   (g >= 0 && w.wr)  ? {28'h0, w.be}   : 32'h0);
    check("ram_addra", {20'h0, ram_addra}, (g >= 0 && w.wr)  ? {20'h0, w.addr} : 32'h0);
    check("ram_dina",  ram_dina,           (g >= 0 && w.wr)  ? w.wdata         : 32'h0);
    check("ram_addrb", {20'h0, ram_addrb}, (g >= 0 && !w.wr) ? {20'h0, w.addr} : 32'h0);
    if (g >= 0) begin
      if (w.wr) begin
        nv = shadow_rd(int'(w.addr));
        for (int k = 0; k < 4; k++) if (w.be[k]) nv[8*k +: 8] = w.wdata[8*k +: 8];
        shadow[int'(w.addr)] = nv;
      end else begin
        sbq.push_back('{port: g, data: shadow_rd(int'(w.addr))});
      end
      if (g == own) run = (run < MH) ? run + 1 : MH;
      else begin own = g; run = 1; end
      last = g;
    end else begin
      own = -1; run = 0;
    end
  endtask

  // Reset for two cycles with both ports requesting; nothing may be granted or written
  task automatic do_reset();
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    model_reset();
    m0_req = 1; m0_wr = 1; m0_be = 4'hF; m1_req = 1; m1_wr = 0; m1_be = 4'hF;
    for (int i = 0; i < 2; i++) begin
      @(negedge HCLK);
      check("rst_m0_gnt",    {31'h0, m0_gnt},    32'h0);
      check("rst_m1_gnt",    {31'h0, m1_gnt},    32'h0);
      check("rst_ram_wea",   {28'h0, ram_wea},   32'h0);
      check("rst_m0_rvalid", {31'h0, m0_rvalid}, 32'h0);
      check("rst_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    end
    @(posedge HCLK); #1;
    m0_req = 0; m1_req = 0; m0_wr = 0; m0_be = 0;
    HRESETn = 1'b1;
  endtask

  // Scoreboard monitor: every read-valid must match the oldest expected read
  initial begin
    exp_t e;
    last_rd[0] = 32'hx; last_rd[1] = 32'hx;
    forever begin
      @(posedge HCLK); #3;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.port == 0 ? "m0_rvalid" : "m1_rvalid",
              {31'h0, (e.port == 0) ? m0_rvalid : m1_rvalid}, 32'h1);
        check("other_rvalid", {31'h0, (e.port == 0) ? m1_rvalid : m0_rvalid}, 32'h0);
        check(e.port == 0 ? "m0_rdata" : "m1_rdata", (e.port == 0) ? m0_rdata : m1_rdata, e.data);
        last_rd[e.port] = (e.port == 0) ? m0_rdata : m1_rdata;
      end else if (m0_rvalid || m1_rvalid) begin
        check("spurious_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
      end
    end
  end

  function automatic mreq_t mk(input logic rq, input logic wr, input logic [3:0] be,
                               input int addr, input logic [31:0] d);
    mreq_t r;
    r.req = rq; r.wr = wr; r.be = be; r.addr = AW'(addr); r.wdata = d;
    return r;
  endfunction

  initial begin
    logic [1:0] obs;
    mreq_t none, a, b;
    none = mk(0, 0, 0, 0, 0);

    do_reset();

    // write then read back on port 0
    cyc(mk(1, 1, 4'hF, 5, 32'hDEADBEEF), none, obs);
    check("wr5_gnt", {30'h0, obs}, 32'h1);
    cyc(mk(1, 0, 4'h0, 5, 0), none, obs);
    check("rd5_gnt", {30'h0, obs}, 32'h1);
    cyc(none, none, obs);
    check("rd5_data", last_rd[0], 32'hDEADBEEF);

    // partial byte write merges with existing word
    cyc(mk(1, 1, 4'hF, 7, 32'hAABBCCDD), none, obs);
    cyc(mk(1, 1, 4'b0101, 7, 32'h11223344), none, obs);
    cyc(mk(1, 0, 4'h0, 7, 0), none, obs);
    cyc(none, none, obs);
    check("rd7_merge", last_rd[0], 32'hAA22CC44);

    // zero byte-enable write is accepted but leaves the word alone
    cyc(none, mk(1, 1, 4'hF, 3, 32'h12345678), obs);
    cyc(none, mk(1, 1, 4'h0, 3, 32'hFFFFFFFF), obs);
    check("be0_gnt", {30'h0, obs}, 32'h2);
    cyc(none, mk(1, 0, 4'h0, 3, 0), obs);
    cyc(none, none, obs);
    check("be0_unchanged", last_rd[1], 32'h12345678);

    // tie from idle after port 0 was served goes to port 1
    cyc(mk(1, 0, 0, 1, 0), none, obs);
    cyc(none, none, obs);
    cyc(mk(1, 0, 0, 2, 0), mk(1, 0, 0, 3, 0), obs);
    check("tie_after_m0", {30'h0, obs}, 32'h2);
    cyc(none, none, obs);
    cyc(none, none, obs);

    // read accepted right before reset yields no rvalid; first tie afterwards goes to port 0
    cyc(none, mk(1, 0, 0, 5, 0), obs);
    do_reset();
    cyc(mk(1, 0, 0, 5, 0), mk(1, 0, 0, 7, 0), obs);
    check("tie_after_rst", {30'h0, obs}, 32'h1);

    // continuous reads from both ports alternate in blocks of MAX_HOLD
    do_reset();
    for (int i = 0; i < 4 * MH; i++) begin
      cyc(mk(1, 0, 0, i, 0), mk(1, 0, 0, i + 100, 0), obs);
      check("hold_pattern", {30'h0, obs}, ((i / MH) % 2 == 0) ? 32'h1 : 32'h2);
    end
    cyc(none, none, obs);

    // random traffic on a small address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      a = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 15), $urandom);
      b = mk($urandom_range(0, 9) < 7, $urandom_range(0, 1), 4'($urandom), $urandom_range(0, 15), $urandom);
      cyc(a, b, obs);
      if (obs == 2'b11) check("both_gnt", {30'h0, obs}, 32'h0);
    end
    cyc(none, none, obs);
    cyc(none, none, obs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
